uart_program_loader: RTL and testbench

Boot-time loader sitting upstream of the CPU core in `cpu_uart_top`. Receives an 8N1 serial byte stream on `uart_rx` and packs bytes little-endian into 32-bit words. Writes the words sequentially into instruction memory, holding the CPU in reset until `CELL_NUMBERS` words are stored. When loading completes it releases the core, which then fetches from address 0.

---
 rtl/uart_program_loader_pkg.sv | 10 +
 rtl/uart_program_loader_if.sv | 14 +
 rtl/uart_program_loader_rx.sv | 112 +++++++++++
 rtl/uart_program_loader.sv | 98 +++++++++
 tb/tb_uart_program_loader.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_program_loader_pkg.sv
// Shared types for the UART program loader: receiver and loader state encodings.
// Also fixes the instruction word width used by the loader and its write port.
package uart_program_loader_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic {LOADING, DONE} load_state_t;

  localparam int WORD_W = 32;

endpackage

// File: rtl/uart_program_loader_if.sv
// Instruction-memory write port driven by the loader (master) into the memory (slave).
interface uart_program_loader_if #(
  parameter int ADDR_W = 6
);
  import uart_program_loader_pkg::*;

  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (output imem_we, imem_addr, imem_wdata);
  modport slave  (input  imem_we, imem_addr, imem_wdata);

endinterface

// File: rtl/uart_program_loader_rx.sv
// 8N1 byte receiver: 2-flop synchroniser, falling-edge start detect, mid-bit sampling.
// Returns to IDLE at mid-stop so back-to-back frames are not lost.
module uart_rx_byte
  import uart_program_loader_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] FULL_LAST = BW'(CLK_DIV - 1);

  logic            sync1_reg, sync2_reg, prev_reg;
  rx_state_t       state_reg, state_next;
  logic [BW-1:0]   baud_reg, baud_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      data_reg, data_next;
  logic            valid_reg, valid_next;
  logic            err_reg, err_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      sync1_reg <= uart_rx;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (prev_reg && !sync2_reg) begin
          state_next = START;
          baud_next  = '0;
        end
      end
      START: begin
        if (baud_reg == HALF_LAST) begin
          baud_next  = '0;
          bit_next   = '0;
          // A start bit that is already high again at mid-bit was a glitch.
          state_next = sync2_reg ? IDLE : DATA;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      DATA: begin
        if (baud_reg == FULL_LAST) begin
          baud_next  = '0;
          shift_next = {sync2_reg, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = STOP;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      STOP: begin
        if (baud_reg == FULL_LAST) begin
          baud_next  = '0;
          state_next = IDLE;
          if (sync2_reg) begin
            valid_next = 1'b1;
            data_next  = shift_reg;
          end else begin
            err_next = 1'b1;
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign byte_valid = valid_reg;
  assign byte_data  = data_reg;
  assign byte_err   = err_reg;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: packs received bytes little-endian into words, writes them to
// instruction memory in order, and holds the CPU in reset until all are stored.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLK_DIV      = 16,
  parameter int CELL_NUMBERS = 64,
  parameter int ADDR_W       = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  uart_program_loader_if.master imem,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  frame_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELL_NUMBERS - 1);

  logic       byte_valid, byte_err;
  logic [7:0] byte_data;

  uart_rx_byte #(.CLK_DIV(CLK_DIV)) rx_byte (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err)
  );

  load_state_t       state_reg, state_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [ADDR_W-1:0] word_cnt_reg, word_cnt_next;
  logic [WORD_W-1:0] word_reg, word_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [WORD_W-1:0] wdata_reg, wdata_next;
  logic              cpu_rst_reg, load_done_reg, frame_err_reg, frame_err_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= LOADING;
      byte_cnt_reg  <= '0;
      word_cnt_reg  <= '0;
      word_reg      <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      cpu_rst_reg   <= 1'b1;
      load_done_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      byte_cnt_reg  <= byte_cnt_next;
      word_cnt_reg  <= word_cnt_next;
      word_reg      <= word_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      // Derived from the registered state so release lags the final write by a cycle.
      cpu_rst_reg   <= (state_reg == LOADING);
      load_done_reg <= (state_reg == DONE);
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    byte_cnt_next  = byte_cnt_reg;
    word_cnt_next  = word_cnt_reg;
    word_next      = word_reg;
    we_next        = 1'b0;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    frame_err_next = frame_err_reg | byte_err;
    if (state_reg == LOADING && byte_valid) begin
      word_next[8*byte_cnt_reg +: 8] = byte_data;
      byte_cnt_next = byte_cnt_reg + 2'd1;
      if (byte_cnt_reg == 2'd3) begin
        we_next       = 1'b1;
        addr_next     = word_cnt_reg;
        wdata_next    = word_next;
        word_cnt_next = word_cnt_reg + ADDR_W'(1);
        if (word_cnt_reg == LAST_ADDR) state_next = DONE;
      end
    end
  end

  assign imem.imem_we    = we_reg;
  assign imem.imem_addr  = addr_reg;
  assign imem.imem_wdata = wdata_reg;
  assign cpu_rst         = cpu_rst_reg;
  assign load_done       = load_done_reg;
  assign frame_err       = frame_err_reg;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench: loader A (4 words) for assembly/full-load/error/glitch/reset tests,
// loader B (1 word) for back-to-back frames; writes are checked against a scoreboard.
`timescale 1ns/1ps
module tb_uart_program_loader;

  localparam int CLK_DIV = 4;
  localparam int ADDR_W  = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic cpu_rst_a, load_done_a, frame_err_a;
  logic cpu_rst_b, load_done_b, frame_err_b;

  uart_program_loader_if #(.ADDR_W(ADDR_W)) bus_a ();
  uart_program_loader_if #(.ADDR_W(ADDR_W)) bus_b ();

  uart_program_loader #(.CLK_DIV(CLK_DIV), .CELL_NUMBERS(4), .ADDR_W(ADDR_W)) dut_a (
    .clk(clk), .rst(rst), .uart_rx(rx_a), .imem(bus_a),
    .cpu_rst(cpu_rst_a), .load_done(load_done_a), .frame_err(frame_err_a)
  );

  uart_program_loader #(.CLK_DIV(CLK_DIV), .CELL_NUMBERS(1), .ADDR_W(ADDR_W)) dut_b (
    .clk(clk), .rst(rst), .uart_rx(rx_b), .imem(bus_b),
    .cpu_rst(cpu_rst_b), .load_done(load_done_b), .frame_err(frame_err_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    bit                last;
  } wr_t;

  typedef struct {
    logic [3:0][7:0] b;
    logic [31:0]     exp_word;
  } vec_t;

  wr_t  q_a[$];
  wr_t  q_b[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   prev_we_a = 0, prev_we_b = 0, done_chk_a = 0, done_chk_b = 0;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (done_chk_a) begin
      done_chk_a = 0;
      check("a_done_cpu_rst", 32'(cpu_rst_a), 32'd0);
      check("a_done_load_done", 32'(load_done_a), 32'd1);
    end
    if (bus_a.imem_we === 1'b1) begin
      $display("A write addr=%0d data=%08h", bus_a.imem_addr, bus_a.imem_wdata);
      check("a_we_not_consecutive", 32'(prev_we_a), 32'd0);
      check("a_cpu_rst_at_write", 32'(cpu_rst_a), 32'd1);
      if (q_a.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_unexpected_write: got addr=%0d data=%08h, required no write",
                 bus_a.imem_addr, bus_a.imem_wdata);
      end else begin
        e = q_a.pop_front();
        check("a_wr_addr", 32'(bus_a.imem_addr), 32'(e.addr));
        check("a_wr_data", bus_a.imem_wdata, e.data);
        if (e.last) done_chk_a = 1;
      end
    end
    prev_we_a = bus_a.imem_we;
  end

  always @(negedge clk) begin
    wr_t e;
    if (done_chk_b) begin
      done_chk_b = 0;
      check("b_done_cpu_rst", 32'(cpu_rst_b), 32'd0);
      check("b_done_load_done", 32'(load_done_b), 32'd1);
    end
    if (bus_b.imem_we === 1'b1) begin
      $display("B write addr=%0d data=%08h", bus_b.imem_addr, bus_b.imem_wdata);
      if (q_b.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_unexpected_write: got addr=%0d data=%08h, required no write",
                 bus_b.imem_addr, bus_b.imem_wdata);
      end else begin
        e = q_b.pop_front();
        check("b_wr_addr", 32'(bus_b.imem_addr), 32'(e.addr));
        check("b_wr_data", bus_b.imem_wdata, e.data);
        if (e.last) done_chk_b = 1;
      end
    end
    prev_we_b = bus_b.imem_we;
  end

  // Caller must be at a negedge; gap_bits=0 chains frames with no idle time.
  task automatic send_byte(input bit to_b, input logic [7:0] b, input logic stop, input int gap_bits);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (to_b) rx_b = frame[i]; else rx_a = frame[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    if (to_b) rx_b = 1'b1; else rx_a = 1'b1;
    repeat (gap_bits * CLK_DIV) @(negedge clk);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d/%0d writes pending, required 0", q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"}, 32'(bus_a.imem_we), 32'd0);
    check({tag, "_addr"}, 32'(bus_a.imem_addr), 32'd0);
    check({tag, "_wdata"}, bus_a.imem_wdata, 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst_a), 32'd1);
    check({tag, "_load_done"}, 32'(load_done_a), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err_a), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("rst");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{b: {8'h00, 8'h10, 8'h05, 8'h13}, exp_word: 32'h00100513};
    vecs[1] = '{b: {8'hDE, 8'hAD, 8'hBE, 8'hEF}, exp_word: 32'hDEADBEEF};
    vecs[2] = '{b: {8'h80, 8'h00, 8'hFF, 8'h01}, exp_word: 32'h8000FF01};
    vecs[3] = '{b: {8'h5A, 8'hA5, 8'h3C, 8'hC3}, exp_word: 32'h5AA53CC3};

    @(negedge clk);
    check_reset_values("init");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Full load from the table; word assembly checked on the first record.
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 3) q_a.push_back('{addr: ADDR_W'(v), data: vecs[v].exp_word, last: (v == 3)});
        send_byte(1'b0, vecs[v].b[k], 1'b1, 2);
      end
      wait_drain(200);
      if (v < 3) begin
        check("a_loading_cpu_rst", 32'(cpu_rst_a), 32'd1);
        check("a_loading_load_done", 32'(load_done_a), 32'd0);
      end
    end
    send_byte(1'b0, 8'h77, 1'b1, 4);
    check("a_after_extra_load_done", 32'(load_done_a), 32'd1);
    check("a_after_extra_cpu_rst", 32'(cpu_rst_a), 32'd0);
    check("a_no_frame_err", 32'(frame_err_a), 32'd0);

    // Bad stop bit: byte dropped, flag sticky, next word unaffected.
    pulse_reset();
    send_byte(1'b0, 8'hAA, 1'b0, 2);
    check("a_frame_err_set", 32'(frame_err_a), 32'd1);
    q_a.push_back('{addr: ADDR_W'(0), data: 32'h00100513, last: 1'b0});
    send_byte(1'b0, 8'h13, 1'b1, 2);
    send_byte(1'b0, 8'h05, 1'b1, 2);
    send_byte(1'b0, 8'h10, 1'b1, 2);
    send_byte(1'b0, 8'h00, 1'b1, 2);
    wait_drain(200);
    check("a_frame_err_sticky", 32'(frame_err_a), 32'd1);

    // Partial word then reset: loading restarts at address 0, lane 0.
    send_byte(1'b0, 8'h11, 1'b1, 2);
    send_byte(1'b0, 8'h22, 1'b1, 2);
    pulse_reset();
    q_a.push_back('{addr: ADDR_W'(0), data: 32'h11223344, last: 1'b0});
    send_byte(1'b0, 8'h44, 1'b1, 2);
    send_byte(1'b0, 8'h33, 1'b1, 2);
    send_byte(1'b0, 8'h22, 1'b1, 2);
    send_byte(1'b0, 8'h11, 1'b1, 2);
    wait_drain(200);

    // One-cycle glitch must not produce a byte or shift the lanes.
    rx_a = 1'b0;
    @(negedge clk);
    rx_a = 1'b1;
    repeat (40) @(negedge clk);
    check("a_glitch_no_frame_err", 32'(frame_err_a), 32'd0);
    q_a.push_back('{addr: ADDR_W'(1), data: 32'hCAFEF00D, last: 1'b0});
    send_byte(1'b0, 8'h0D, 1'b1, 2);
    send_byte(1'b0, 8'hF0, 1'b1, 2);
    send_byte(1'b0, 8'hFE, 1'b1, 2);
    send_byte(1'b0, 8'hCA, 1'b1, 2);
    wait_drain(200);
    check("a_glitch_cpu_rst", 32'(cpu_rst_a), 32'd1);

    // Back-to-back frames into the single-word loader.
    check("b_pre_load_done", 32'(load_done_b), 32'd0);
    q_b.push_back('{addr: ADDR_W'(0), data: 32'h12345678, last: 1'b1});
    send_byte(1'b1, 8'h78, 1'b1, 0);
    send_byte(1'b1, 8'h56, 1'b1, 0);
    send_byte(1'b1, 8'h34, 1'b1, 0);
    send_byte(1'b1, 8'h12, 1'b1, 2);
    wait_drain(200);
    check("b_load_done", 32'(load_done_b), 32'd1);
    check("b_frame_err", 32'(frame_err_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
